// File: rtl/multicycle_ctrl.sv
// Multi-cycle main controller: FETCH/DECODE/EXEC/MEM/WB sequencing
// with a memory ready handshake, a sticky illegal-opcode trap and an
// optional retired-instruction counter.
//
// Ports:
//   clk, reset     : rising-edge clock, synchronous active-high reset
//   op_code        : opcode from memory read data, latched in FETCH
//   zero           : ALU zero flag, used by beq/bne in EXEC
//   mem_ready      : memory handshake, completes a pending request
//   mem_read/write : memory request strobes
//   ir_write       : load instruction register
//   pc_write       : update PC, pc_src selects the source
//   reg_write      : register file write, reg_dst selects the target
//   mem_to_reg     : writeback selects memory data
//   alu_src        : 0 register operand, 1 immediate
//   alu_control    : ALU operation code
//   illegal        : sticky trap flag
//   instr_count    : retired-instruction count
//
// Optional feature macro: MULTICYCLE_CTRL_PERF_CNT_EN enables the
// CNT_W-bit instruction counter; otherwise instr_count is tied to 0.

module multicycle_ctrl #(
  parameter int OP_W  = 5,
  parameter int ALU_W = 4,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [OP_W-1:0]  op_code,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             reg_write,
  output logic [1:0]       reg_dst,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [ALU_W-1:0] alu_control,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_ALUWB,
    S_MEMWB,
    S_TRAP
  } state_t;

  state_t          state;
  logic [OP_W-1:0] op_q;
  logic            illegal_q;

  // Opcode class decode from the latched opcode.
  logic [4:0] op5;
  logic       hi_ok;
  logic       is_j;
  logic       is_jal;
  logic       is_jr;
  logic       is_r;
  logic       is_addi;
  logic       is_subi;
  logic       is_lw;
  logic       is_sw;
  logic       is_beq;
  logic       is_bne;
  logic       is_jump;
  logic       is_exec;
  logic [3:0] r_alu;

  assign op5 = op_q[4:0];

  // Any set bit above bit 4 makes the opcode illegal.
  generate
    if (OP_W > 5) begin : g_hi
      assign hi_ok = (op_q[OP_W-1:5] == '0);
    end else begin : g_nohi
      assign hi_ok = 1'b1;
    end
  endgenerate

  assign is_j    = hi_ok && (op5 == 5'b00000);
  assign is_jal  = hi_ok && (op5 == 5'b00111);
  assign is_jr   = hi_ok && (op5 == 5'b10010);
  assign is_r    = hi_ok && (op5 >= 5'b01000)
                         && (op5 <= 5'b10100)
                         && (op5 != 5'b10010);
  assign is_addi = hi_ok && (op5 == 5'b11000);
  assign is_subi = hi_ok && (op5 == 5'b11001);
  assign is_lw   = hi_ok && (op5 == 5'b11010);
  assign is_sw   = hi_ok && (op5 == 5'b11011);
  assign is_beq  = hi_ok && (op5 == 5'b11100);
  assign is_bne  = hi_ok && (op5 == 5'b11101);

  assign is_jump = is_j | is_jal | is_jr;
  assign is_exec = is_r | is_addi | is_subi
                 | is_lw | is_sw | is_beq | is_bne;

  // R-type opcodes 01000..10100 map onto ALU ops 0..12.
  assign r_alu = op5[3:0] - 4'd8;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_FETCH;
      op_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (mem_ready) begin
            op_q  <= op_code;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_jump) begin
            state <= S_FETCH;
          end else if (is_exec) begin
            state <= S_EXEC;
          end else begin
            state     <= S_TRAP;
            illegal_q <= 1'b1;
          end
        end
        S_EXEC: begin
          if (is_lw || is_sw) begin
            state <= S_MEM;
          end else if (is_beq || is_bne) begin
            state <= S_FETCH;
          end else begin
            state <= S_ALUWB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            state <= is_lw ? S_MEMWB : S_FETCH;
          end
        end
        S_ALUWB: state <= S_FETCH;
        S_MEMWB: state <= S_FETCH;
        S_TRAP:  state <= S_TRAP;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 2'b00;
    mem_to_reg  = 1'b0;
    alu_src     = 1'b0;
    alu_control = '0;
    unique case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: begin
        unique case (1'b1)
          is_j: begin
            pc_write = 1'b1;
            pc_src   = 2'b10;
          end
          is_jal: begin
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            reg_write = 1'b1;
            reg_dst   = 2'b10;
          end
          is_jr: begin
            pc_write = 1'b1;
            pc_src   = 2'b11;
          end
          default: ;
        endcase
      end
      S_EXEC: begin
        unique case (1'b1)
          is_r: begin
            alu_control = ALU_W'(r_alu);
          end
          is_addi: begin
            alu_src = 1'b1;
          end
          is_subi: begin
            alu_src     = 1'b1;
            alu_control = ALU_W'(1);
          end
          is_lw, is_sw: begin
            alu_src = 1'b1;
          end
          is_beq: begin
            alu_control = ALU_W'(1);
            pc_src      = 2'b01;
            pc_write    = zero;
          end
          is_bne: begin
            alu_control = ALU_W'(1);
            pc_src      = 2'b01;
            pc_write    = !zero;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        mem_read  = is_lw;
        mem_write = is_sw;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = is_r ? 2'b01 : 2'b00;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      default: ;
    endcase
    // Reset cycle: nothing may be written; a read request is harmless
    // and drops on the next cycle.
    if (reset) begin
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'b00;
      reg_write   = 1'b0;
      reg_dst     = 2'b00;
      mem_to_reg  = 1'b0;
      alu_src     = 1'b0;
      alu_control = '0;
    end
  end

  assign illegal = illegal_q;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (state == S_FETCH && mem_ready) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign instr_count = cnt_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl: directed scenarios plus random
// instruction streams checked against a per-instruction step model.

module tb_multicycle_ctrl;

`ifdef MULTICYCLE_CTRL_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op_code = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       mem_read, mem_write, ir_write, pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic [1:0] reg_dst;
  logic       mem_to_reg, alu_src;
  logic [3:0] alu_control;
  logic       illegal;
  logic [3:0] instr_count;

  multicycle_ctrl #(.OP_W(6), .ALU_W(4), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .op_code(op_code), .zero(zero),
    .mem_ready(mem_ready), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .alu_control(alu_control), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // One post-fetch cycle of an instruction: what it drives and
  // whether it must wait for mem_ready before moving on.
  typedef struct packed {
    bit       mr;
    bit       mw;
    bit       pcw;
    bit [1:0] pcs;
    bit       rw;
    bit [1:0] rd;
    bit       m2r;
    bit       asrc;
    bit [3:0] alu;
    bit       mem_wait;
    bit [1:0] br;
    bit       trap;
  } step_t;

  step_t sq[$];
  step_t run[$];
  bit    mvalid = 1'b0;
  bit    trapped = 1'b0;
  int    cnt = 0;
  int    checks = 0;
  int    errors = 0;

  function automatic int plan(input logic [5:0] op);
    step_t d, e, w;
    logic [4:0] o;
    sq.delete();
    d = '0; e = '0; w = '0;
    o = op[4:0];
    if (op[5]) begin
      d.trap = 1'b1;
      sq.push_back(d);
      return sq.size();
    end
    case (o)
      5'd0: begin
        d.pcw = 1; d.pcs = 2'b10;
        sq.push_back(d);
      end
      5'd7: begin
        d.pcw = 1; d.pcs = 2'b10; d.rw = 1; d.rd = 2'b10;
        sq.push_back(d);
      end
      5'd18: begin
        d.pcw = 1; d.pcs = 2'b11;
        sq.push_back(d);
      end
      5'd24, 5'd25: begin
        e.asrc = 1; e.alu = (o == 5'd25) ? 4'd1 : 4'd0;
        w.rw = 1;
        sq.push_back(d); sq.push_back(e); sq.push_back(w);
      end
      5'd26: begin
        e.asrc = 1;
        w.mr = 1; w.mem_wait = 1;
        sq.push_back(d); sq.push_back(e); sq.push_back(w);
        w = '0; w.rw = 1; w.m2r = 1;
        sq.push_back(w);
      end
      5'd27: begin
        e.asrc = 1;
        w.mw = 1; w.mem_wait = 1;
        sq.push_back(d); sq.push_back(e); sq.push_back(w);
      end
      5'd28, 5'd29: begin
        e.alu = 4'd1; e.pcs = 2'b01;
        e.br = (o == 5'd28) ? 2'd1 : 2'd2;
        sq.push_back(d); sq.push_back(e);
      end
      default: begin
        if (o >= 5'd8 && o <= 5'd20) begin
          e.alu = 4'(o - 5'd8);
          w.rw = 1; w.rd = 2'b01;
          sq.push_back(d); sq.push_back(e); sq.push_back(w);
        end else begin
          d.trap = 1'b1;
          sq.push_back(d);
        end
      end
    endcase
    return sq.size();
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model at the
  // falling edge, then advance the model past the coming rising edge.
  task automatic cyc(input bit r, input logic [5:0] op,
                     input bit rdy, input bit z);
    step_t s;
    bit e_mr, e_mw, e_irw, e_pcw, e_rw, e_m2r, e_as;
    bit [1:0] e_pcs, e_rd;
    bit [3:0] e_alu;
    @(posedge clk);
    #1;
    reset = r; op_code = op; mem_ready = rdy; zero = z;
    @(negedge clk);
    e_mr = 0; e_mw = 0; e_irw = 0; e_pcw = 0; e_rw = 0;
    e_m2r = 0; e_as = 0; e_pcs = 0; e_rd = 0; e_alu = 0;
    if (!trapped) begin
      if (run.size() == 0) begin
        e_mr = 1; e_irw = rdy; e_pcw = rdy;
      end else begin
        s = run[0];
        e_mr = s.mr; e_mw = s.mw; e_rw = s.rw; e_m2r = s.m2r;
        e_as = s.asrc; e_pcs = s.pcs; e_rd = s.rd; e_alu = s.alu;
        e_pcw = s.pcw | (s.br == 2'd1 && z) | (s.br == 2'd2 && !z);
      end
    end
    if (r) begin
      e_mw = 0; e_irw = 0; e_pcw = 0; e_rw = 0; e_m2r = 0;
      e_as = 0; e_pcs = 0; e_rd = 0; e_alu = 0;
    end
    if (mvalid) begin
      chk("mem_read", mem_read, e_mr);
      chk("mem_write", mem_write, e_mw);
      chk("ir_write", ir_write, e_irw);
      chk("pc_write", pc_write, e_pcw);
      chk("pc_src", pc_src, e_pcs);
      chk("reg_write", reg_write, e_rw);
      chk("reg_dst", reg_dst, e_rd);
      chk("mem_to_reg", mem_to_reg, e_m2r);
      chk("alu_src", alu_src, e_as);
      chk("alu_control", alu_control, e_alu);
      chk("illegal", illegal, trapped);
      chk("instr_count", instr_count, PERF ? cnt : 0);
    end
    if (r) begin
      mvalid = 1; trapped = 0; cnt = 0;
      run.delete();
    end else if (mvalid && !trapped) begin
      if (run.size() == 0) begin
        if (rdy) begin
          void'(plan(op));
          run = sq;
          cnt = (cnt + 1) % 16;
        end
      end else begin
        s = run[0];
        if (!s.mem_wait || rdy) begin
          void'(run.pop_front());
          if (s.trap) trapped = 1;
        end
      end
    end
  endtask

  localparam logic [5:0] OP_ADD = 6'b001000;
  localparam logic [5:0] OP_LW  = 6'b011010;
  localparam logic [5:0] OP_SW  = 6'b011011;
  localparam logic [5:0] OP_BEQ = 6'b011100;
  localparam logic [5:0] OP_BNE = 6'b011101;
  localparam logic [5:0] OP_J   = 6'b000000;
  localparam logic [5:0] OP_JAL = 6'b000111;
  localparam logic [5:0] OP_BAD = 6'b000101;

  logic [5:0] legal_ops [18] = '{
    6'd0, 6'd7, 6'd18, 6'd8, 6'd9, 6'd12, 6'd16, 6'd17, 6'd19,
    6'd20, 6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29, 6'd26, 6'd27
  };

  initial begin
    logic [5:0] op;
    int lat;

    // Model pins: post-fetch cycle counts from the latency table.
    chk("lat_j", plan(OP_J) + 1, 2);
    chk("lat_beq", plan(OP_BEQ) + 1, 3);
    chk("lat_add", plan(OP_ADD) + 1, 4);
    chk("lat_sw", plan(OP_SW) + 1, 4);
    chk("lat_lw", plan(OP_LW) + 1, 5);
    chk("lat_hi", plan(6'b101000) + 1, 2);

    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("rst_mem_read", mem_read, 1);
    chk("rst_ir_write", ir_write, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_count", instr_count, 0);

    // add: 4 cycles, pc_write only in FETCH
    cyc(0, OP_ADD, 1, 0);
    chk("add_f_pcw", pc_write, 1);
    chk("add_f_irw", ir_write, 1);
    cyc(0, 0, 1, 0);
    chk("add_d_pcw", pc_write, 0);
    chk("add_d_cnt", instr_count, PERF ? 1 : 0);
    cyc(0, 0, 1, 0);
    chk("add_e_alu", alu_control, 0);
    chk("add_e_src", alu_src, 0);
    cyc(0, 0, 1, 0);
    chk("add_w_rw", reg_write, 1);
    chk("add_w_rd", reg_dst, 2'b01);
    chk("add_w_pcw", pc_write, 0);
    cyc(0, 0, 0, 0);
    chk("add_next_fetch", mem_read, 1);

    // lw with two wait cycles in FETCH and in MEM: 9 cycles
    lat = 0;
    cyc(0, OP_LW, 0, 0); lat++;
    chk("lw_wait_f", mem_read, 1);
    cyc(0, OP_LW, 0, 0); lat++;
    cyc(0, OP_LW, 1, 0); lat++;
    cyc(0, 0, 1, 0); lat++;
    cyc(0, 0, 1, 0); lat++;
    chk("lw_e_src", alu_src, 1);
    cyc(0, 0, 0, 0); lat++;
    chk("lw_m_wait1", mem_read, 1);
    cyc(0, 0, 0, 0); lat++;
    chk("lw_m_wait2", mem_read, 1);
    cyc(0, 0, 1, 0); lat++;
    cyc(0, 0, 1, 0); lat++;
    chk("lw_wb_rw", reg_write, 1);
    chk("lw_wb_m2r", mem_to_reg, 1);
    chk("lw_total", lat, 9);

    // branches
    cyc(0, OP_BEQ, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1);
    chk("beq_z1_pcw", pc_write, 1);
    chk("beq_z1_pcs", pc_src, 2'b01);
    cyc(0, OP_BNE, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 1);
    chk("bne_z1_pcw", pc_write, 0);
    cyc(0, OP_BNE, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    chk("bne_z0_pcw", pc_write, 1);

    // jal
    cyc(0, OP_JAL, 1, 0); cyc(0, 0, 1, 0);
    chk("jal_pcw", pc_write, 1);
    chk("jal_pcs", pc_src, 2'b10);
    chk("jal_rw", reg_write, 1);
    chk("jal_rd", reg_dst, 2'b10);
    cyc(0, 0, 0, 0);
    chk("jal_to_fetch", mem_read, 1);

    // reset during sw memory wait
    cyc(0, OP_SW, 1, 0); cyc(0, 0, 1, 0); cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("sw_m_mw", mem_write, 1);
    cyc(1, 0, 0, 0);
    chk("sw_rst_mw", mem_write, 0);
    cyc(0, 0, 0, 0);
    chk("sw_after_mw", mem_write, 0);
    chk("sw_after_fetch", mem_read, 1);

    // illegal opcode, trap held until reset
    cyc(0, OP_BAD, 1, 0); cyc(0, 0, 1, 0);
    for (int i = 0; i < 12; i++) begin
      cyc(0, 6'($urandom), 1'($urandom), 1'($urandom));
      chk("trap_ill", illegal, 1);
      chk("trap_mr", mem_read, 0);
      chk("trap_pcw", pc_write, 0);
    end
    cyc(1, 0, 1, 0);
    cyc(0, 0, 0, 0);
    chk("trap_clr", illegal, 0);
    chk("trap_fetch", mem_read, 1);

    // counter wrap: 16 fetches with a 4-bit counter
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, OP_J, 1, 0);
      cyc(0, 0, 1, 0);
      if (i == 14) chk("cnt_15", instr_count, PERF ? 15 : 0);
    end
    cyc(0, 0, 0, 0);
    chk("cnt_wrap", instr_count, 0);

    // random instruction streams
    for (int i = 0; i < 3000; i++) begin
      int pick;
      bit r;
      pick = $urandom_range(0, 99);
      if (pick < 80) op = legal_ops[$urandom_range(0, 17)];
      else if (pick < 95) op = {1'b0, 5'($urandom)};
      else op = 6'($urandom);
      if (trapped) r = ($urandom_range(0, 7) == 0);
      else r = ($urandom_range(0, 149) == 0);
      cyc(r, op, $urandom_range(0, 9) < 7, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
